// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: instruction fields,
// ALU operations, FSM states and the decoded operation class.
package mips_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_COP1  = 6'h11;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] FMT_S = 5'h10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_FPU_WAIT = 3'd5,
    S_TRAP     = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OC_NOP, OC_ADD, OC_SUB, OC_SLT, OC_JR, OC_ADDI, OC_XORI, OC_LW,
    OC_SW, OC_BEQ, OC_BNE, OC_J, OC_JAL, OC_FPU, OC_ILLEGAL
  } op_class_t;

  function automatic logic is_rtype_alu(input op_class_t c);
    return (c == OC_ADD) || (c == OC_SUB) || (c == OC_SLT);
  endfunction

endpackage

// File: rtl/mips_op_classify.sv
// Combinational instruction-field decoder producing the operation class.
module mips_op_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] functcode,
  input  logic [4:0] fmt,
  output op_class_t  op_class
);

  always_comb begin
    op_class = OC_ILLEGAL;
    case (opcode)
      OPC_RTYPE: begin
        case (functcode)
          FN_ADD:  op_class = OC_ADD;
          FN_SUB:  op_class = OC_SUB;
          FN_SLT:  op_class = OC_SLT;
          FN_JR:   op_class = OC_JR;
          default: op_class = OC_ILLEGAL;
        endcase
      end
      OPC_J:    op_class = OC_J;
      OPC_JAL:  op_class = OC_JAL;
      OPC_BEQ:  op_class = OC_BEQ;
      OPC_BNE:  op_class = OC_BNE;
      OPC_ADDI: op_class = OC_ADDI;
      OPC_XORI: op_class = OC_XORI;
      OPC_LW:   op_class = OC_LW;
      OPC_SW:   op_class = OC_SW;
      // Only single-precision ADD/SUB/MUL/DIV are supported by the FPU.
      OPC_COP1: op_class = (fmt == FMT_S && functcode[5:2] == 4'd0) ? OC_FPU : OC_ILLEGAL;
      default:  op_class = OC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory/FPU handshakes and bounded waits
// that fall into a sticky TRAP state.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int FPU_TIMEOUT = 16,
  parameter int MEM_TIMEOUT = 8,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         functcode,
  input  logic [4:0]         fmt,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               fpu_done,
  input  logic               fpu_exc,
  output logic               ir_we,
  output logic               pc_we,
  output logic               regWrite,
  output logic               fregWrite,
  output logic               dm_re,
  output logic               dm_we,
  output logic               muxA_en,
  output logic               muxWD3_en,
  output logic               fpu_start,
  output logic               trap,
  output logic [1:0]         muxB_en,
  output logic [1:0]         regWriteAddSelect,
  output logic [1:0]         muxPC,
  output logic [1:0]         fpu_op,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [2:0]         state
);

  localparam int MAX_TIMEOUT = (FPU_TIMEOUT > MEM_TIMEOUT) ? FPU_TIMEOUT : MEM_TIMEOUT;
  localparam int CNT_W       = $clog2(MAX_TIMEOUT + 1);

  state_t           state_reg, state_next;
  op_class_t        op_class_reg, op_class_dec;
  logic [CNT_W-1:0] wait_cnt_reg;

  mips_op_classify u_classify (
    .opcode    (opcode),
    .functcode (functcode),
    .fmt       (fmt),
    .op_class  (op_class_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_FETCH;
      op_class_reg <= OC_NOP;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        op_class_reg <= op_class_dec;
      // Counter restarts on every entry into a wait state and runs only while it stays there.
      if ((state_reg == S_MEM || state_reg == S_FPU_WAIT) && state_next == state_reg)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else
        wait_cnt_reg <= '0;
    end
  end

  assign state = state_reg;

  always_comb begin
    state_next        = state_reg;
    ir_we             = 1'b0;
    pc_we             = 1'b0;
    regWrite          = 1'b0;
    fregWrite         = 1'b0;
    dm_re             = 1'b0;
    dm_we             = 1'b0;
    muxA_en           = 1'b0;
    muxWD3_en         = 1'b0;
    fpu_start         = 1'b0;
    trap              = 1'b0;
    muxB_en           = 2'd0;
    regWriteAddSelect = 2'd0;
    muxPC             = 2'd0;
    fpu_op            = 2'd0;
    ALUop             = '0;
    // Outputs are gated by reset_n so they drop the moment reset asserts.
    if (reset_n) begin
      case (state_reg)
        S_FETCH: begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
        S_DECODE: begin
          case (op_class_dec)
            OC_ADD, OC_SUB, OC_SLT, OC_JR, OC_ADDI, OC_XORI,
            OC_LW, OC_SW, OC_BEQ, OC_BNE: state_next = S_EXEC;
            OC_J: begin
              pc_we      = 1'b1;
              muxPC      = 2'd1;
              state_next = S_FETCH;
            end
            OC_JAL: begin
              regWrite          = 1'b1;
              muxA_en           = 1'b1;
              muxB_en           = 2'd2;
              muxWD3_en         = 1'b1;
              regWriteAddSelect = 2'd1;
              pc_we             = 1'b1;
              muxPC             = 2'd1;
              state_next        = S_FETCH;
            end
            OC_FPU: begin
              fpu_start  = 1'b1;
              fpu_op     = functcode[1:0];
              state_next = S_FPU_WAIT;
            end
            default: state_next = S_TRAP;
          endcase
        end
        S_EXEC: begin
          case (op_class_reg)
            OC_SUB, OC_BEQ, OC_BNE: ALUop = ALUOP_W'(ALU_SUB);
            OC_XORI:                ALUop = ALUOP_W'(ALU_XOR);
            OC_SLT:                 ALUop = ALUOP_W'(ALU_SLT);
            default:                ALUop = ALUOP_W'(ALU_ADD);
          endcase
          if (is_rtype_alu(op_class_reg) || op_class_reg == OC_JR ||
              op_class_reg == OC_BEQ || op_class_reg == OC_BNE)
            muxB_en = 2'd1;
          case (op_class_reg)
            OC_BEQ: begin
              muxPC      = 2'd3;
              pc_we      = zero;
              state_next = S_FETCH;
            end
            OC_BNE: begin
              muxPC      = 2'd3;
              pc_we      = ~zero;
              state_next = S_FETCH;
            end
            OC_JR: begin
              pc_we      = 1'b1;
              muxPC      = 2'd2;
              state_next = S_FETCH;
            end
            OC_LW, OC_SW: state_next = S_MEM;
            default:      state_next = S_WB;
          endcase
        end
        S_MEM: begin
          dm_re = (op_class_reg == OC_LW);
          dm_we = (op_class_reg != OC_LW);
          if (mem_ready)
            state_next = (op_class_reg == OC_LW) ? S_WB : S_FETCH;
          else if (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1))
            state_next = S_TRAP;
        end
        S_WB: begin
          regWrite          = 1'b1;
          muxWD3_en         = (op_class_reg != OC_LW);
          regWriteAddSelect = is_rtype_alu(op_class_reg) ? 2'd2 : 2'd0;
          state_next        = S_FETCH;
        end
        S_FPU_WAIT: begin
          if (fpu_done) begin
            fregWrite  = ~fpu_exc;
            state_next = fpu_exc ? S_TRAP : S_FETCH;
          end else if (wait_cnt_reg == CNT_W'(FPU_TIMEOUT - 1)) begin
            state_next = S_TRAP;
          end
        end
        default: begin
          trap       = 1'b1;
          state_next = S_TRAP;
        end
      endcase
    end
  end

endmodule
